// File: rtl/ray_pkg.sv
// Shared types and widths for the ray/sphere shading stage.
// No logic of its own; latency n/a.
// No handshakes here; flow control lives in the modules that import it.
package ray_pkg;

    localparam int DIR_W   = 16;          // usable signed width of a direction component
    localparam int COORD_W = 11;          // camera / sphere coordinate width (unsigned)
    localparam int DIM_W   = 13;          // frame dimension / pixel coordinate width
    localparam int ACC_W   = 64;          // multiplier product and accumulator width
    localparam int OC_W    = COORD_W + 1; // signed camera-minus-centre offset width
    // The ray length term a can reach 3*2^30, one bit beyond a signed 32-bit
    // value, so multiplier operands carry one extra bit to keep a*c exact.
    localparam int OP_W    = 33;

    localparam logic [3:0] LAST_STEP = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESOLVE,
        OUT
    } shader_state_t;

endpackage

// File: rtl/ray_mac.sv
// Signed multiplier with a 64-bit accumulator (clear / add / subtract).
// Product is combinational; accumulator updates on the next clk edge.
// No backpressure: the controlling FSM issues at most one operation per cycle.
module ray_mac
    import ray_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    add,
    input  logic                    sub,
    input  logic signed [OP_W-1:0]  op_a,
    input  logic signed [OP_W-1:0]  op_b,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] prod
);

    logic signed [ACC_W-1:0] acc_d;

    // Operands are sign-extended to the accumulator width; the low 64 bits are exact.
    assign prod = ACC_W'(op_a) * ACC_W'(op_b);

    // Next accumulator value: optional clear, then add or subtract the product.
    always_comb begin
        acc_d = clr ? '0 : acc;
        if (add) begin
            acc_d = acc_d + prod;
        end else if (sub) begin
            acc_d = acc_d - prod;
        end
    end

    // Accumulator register, held when no operation is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr || add || sub) begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/ray_sphere_shader.sv
// Resolves one ray against one sphere on a shared multiplier and emits a shaded, tagged pixel.
// Latency: pix_valid 12 edges after accept (1 edge for an out-of-range ray).
// One ray in flight; in_ready only in IDLE; pix_* held until pix_ready.
module ray_sphere_shader
    import ray_pkg::*;
#(
    parameter logic [7:0] HIT_COLOR  = 8'hFF,
    parameter logic [7:0] MISS_COLOR = 8'h20,
    parameter int         DIR_W      = ray_pkg::DIR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        ray_dir_x,
    input  logic [31:0]        ray_dir_y,
    input  logic [31:0]        ray_dir_z,
    input  logic [COORD_W-1:0] camera_pos_x,
    input  logic [COORD_W-1:0] camera_pos_y,
    input  logic [COORD_W-1:0] camera_pos_z,
    input  logic [COORD_W-1:0] sphere_x,
    input  logic [COORD_W-1:0] sphere_y,
    input  logic [COORD_W-1:0] sphere_z,
    input  logic [COORD_W-1:0] sphere_r,
    input  logic [DIM_W-1:0]   image_width,
    input  logic [DIM_W-1:0]   image_height,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [7:0]         pix_color,
    output logic               pix_hit,
    output logic               pix_oor,
    output logic [DIM_W-1:0]   pix_x,
    output logic [DIM_W-1:0]   pix_y,
    output logic               frame_done
);

    localparam logic signed [31:0] DIR_MAX = (32'sd1 <<< (DIR_W - 1)) - 32'sd1;
    localparam logic signed [31:0] DIR_MIN = -(32'sd1 <<< (DIR_W - 1));

    function automatic logic out_of_range(input logic [31:0] v);
        return ($signed(v) > DIR_MAX) || ($signed(v) < DIR_MIN);
    endfunction

    shader_state_t           state_q, state_d;
    logic [3:0]              step_q;
    logic signed [OP_W-1:0]  dx_q, dy_q, dz_q;
    logic signed [OC_W-1:0]  ocx_q, ocy_q, ocz_q;
    logic [COORD_W-1:0]      r_q;
    logic signed [OP_W-1:0]  a_q, b_q, c_q;
    logic                    accept, ray_oor, hit;
    logic                    mac_clr, mac_add, mac_sub;
    logic signed [OP_W-1:0]  op_a, op_b;
    logic signed [ACC_W-1:0] mac_acc, mac_prod, disc;
    logic [DIM_W-1:0]        x_last, y_last;

    assign in_ready  = reset_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign ray_oor   = out_of_range(ray_dir_x) || out_of_range(ray_dir_y) || out_of_range(ray_dir_z);
    assign pix_valid = (state_q == OUT);

    // In RESOLVE the accumulator still holds b*b while the multiplier forms a*c.
    assign disc = mac_acc - mac_prod;
    assign hit  = !disc[ACC_W-1] && (b_q[OP_W-1] || c_q[OP_W-1]) && (a_q != '0);

    // A zero dimension behaves as a dimension of one.
    assign x_last = (image_width  == '0) ? '0 : image_width  - 1'b1;
    assign y_last = (image_height == '0) ? '0 : image_height - 1'b1;

    ray_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .add     (mac_add),
        .sub     (mac_sub),
        .op_a    (op_a),
        .op_b    (op_b),
        .acc     (mac_acc),
        .prod    (mac_prod)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and multiplier sequencing: a in steps 0-2, b in 3-5, c in 6-9, b*b in 10.
    always_comb begin
        state_d = state_q;
        mac_clr = 1'b0;
        mac_add = 1'b0;
        mac_sub = 1'b0;
        op_a    = '0;
        op_b    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mac_clr = 1'b1;
                    state_d = ray_oor ? OUT : CALC;
                end
            end
            CALC: begin
                mac_add = 1'b1;
                mac_clr = (step_q == 4'd0) || (step_q == 4'd3) || (step_q == 4'd6) || (step_q == LAST_STEP);
                case (step_q)
                    4'd0:    begin op_a = dx_q;        op_b = dx_q;        end
                    4'd1:    begin op_a = dy_q;        op_b = dy_q;        end
                    4'd2:    begin op_a = dz_q;        op_b = dz_q;        end
                    4'd3:    begin op_a = OP_W'(ocx_q); op_b = dx_q;       end
                    4'd4:    begin op_a = OP_W'(ocy_q); op_b = dy_q;       end
                    4'd5:    begin op_a = OP_W'(ocz_q); op_b = dz_q;       end
                    4'd6:    begin op_a = OP_W'(ocx_q); op_b = OP_W'(ocx_q); end
                    4'd7:    begin op_a = OP_W'(ocy_q); op_b = OP_W'(ocy_q); end
                    4'd8:    begin op_a = OP_W'(ocz_q); op_b = OP_W'(ocz_q); end
                    4'd9:    begin
                        op_a    = OP_W'(r_q);
                        op_b    = OP_W'(r_q);
                        mac_add = 1'b0;
                        mac_sub = 1'b1;
                    end
                    default: begin op_a = b_q;         op_b = b_q;         end
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                op_a    = a_q;
                op_b    = c_q;
                state_d = OUT;
            end
            OUT: begin
                if (pix_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ray latch, step counter, snapshots of a/b/c, and the shading result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            dz_q      <= '0;
            ocx_q     <= '0;
            ocy_q     <= '0;
            ocz_q     <= '0;
            r_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            pix_hit   <= 1'b0;
            pix_oor   <= 1'b0;
            pix_color <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        step_q    <= '0;
                        dx_q      <= OP_W'($signed(ray_dir_x));
                        dy_q      <= OP_W'($signed(ray_dir_y));
                        dz_q      <= OP_W'($signed(ray_dir_z));
                        ocx_q     <= {1'b0, camera_pos_x} - {1'b0, sphere_x};
                        ocy_q     <= {1'b0, camera_pos_y} - {1'b0, sphere_y};
                        ocz_q     <= {1'b0, camera_pos_z} - {1'b0, sphere_z};
                        r_q       <= sphere_r;
                        pix_oor   <= ray_oor;
                        pix_hit   <= 1'b0;
                        pix_color <= MISS_COLOR;
                    end
                end
                CALC: begin
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'd3) a_q <= mac_acc[OP_W-1:0];
                    if (step_q == 4'd6) b_q <= mac_acc[OP_W-1:0];
                    if (step_q == LAST_STEP) c_q <= mac_acc[OP_W-1:0];
                end
                RESOLVE: begin
                    pix_hit   <= hit;
                    pix_color <= hit ? HIT_COLOR : MISS_COLOR;
                end
                default: ;
            endcase
        end
    end

    // Raster position advances on each pixel handshake; frame_done marks the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_valid && pix_ready) begin
                if (pix_x >= x_last) begin
                    pix_x <= '0;
                    if (pix_y >= y_last) begin
                        pix_y      <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        pix_y <= pix_y + 1'b1;
                    end
                end else begin
                    pix_x <= pix_x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_sphere_shader.sv
module tb_ray_sphere_shader;

    typedef struct packed {
        logic        hit;
        logic        oor;
        logic [7:0]  color;
        logic [12:0] x;
        logic [12:0] y;
    } pix_t;

    logic        clk, reset_n, in_valid, in_ready, pix_valid, pix_ready;
    logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
    logic [10:0] camera_pos_x, camera_pos_y, camera_pos_z;
    logic [10:0] sphere_x, sphere_y, sphere_z, sphere_r;
    logic [12:0] image_width, image_height, pix_x, pix_y;
    logic [7:0]  pix_color;
    logic        pix_hit, pix_oor, frame_done;

    pix_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   mx = 0, my = 0;
    int   cam_x, cam_y, cam_z, sph_x, sph_y, sph_z, rad;

    ray_sphere_shader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ray_dir_x    (ray_dir_x),
        .ray_dir_y    (ray_dir_y),
        .ray_dir_z    (ray_dir_z),
        .camera_pos_x (camera_pos_x),
        .camera_pos_y (camera_pos_y),
        .camera_pos_z (camera_pos_z),
        .sphere_x     (sphere_x),
        .sphere_y     (sphere_y),
        .sphere_z     (sphere_z),
        .sphere_r     (sphere_r),
        .image_width  (image_width),
        .image_height (image_height),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_color    (pix_color),
        .pix_hit      (pix_hit),
        .pix_oor      (pix_oor),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: ray from camera along d against the sphere, integer discriminant.
    function automatic pix_t model(input longint dx, input longint dy, input longint dz);
        pix_t   e;
        longint ox, oy, oz, a, b, c, disc;
        e.x = 13'(mx);
        e.y = 13'(my);
        if (dx > 32767 || dx < -32768 || dy > 32767 || dy < -32768 || dz > 32767 || dz < -32768) begin
            e.hit = 1'b0; e.oor = 1'b1; e.color = 8'h20;
            return e;
        end
        ox = longint'(cam_x) - longint'(sph_x);
        oy = longint'(cam_y) - longint'(sph_y);
        oz = longint'(cam_z) - longint'(sph_z);
        a = dx*dx + dy*dy + dz*dz;
        b = ox*dx + oy*dy + oz*dz;
        c = ox*ox + oy*oy + oz*oz - longint'(rad)*longint'(rad);
        disc = b*b - a*c;
        e.oor = 1'b0;
        e.hit = (disc >= 0) && (b < 0 || c < 0) && (a != 0);
        e.color = e.hit ? 8'hFF : 8'h20;
        return e;
    endfunction

    task automatic next_coord();
        int w, h;
        w = (image_width == 0) ? 1 : int'(image_width);
        h = (image_height == 0) ? 1 : int'(image_height);
        mx++;
        if (mx >= w) begin
            mx = 0;
            my++;
            if (my >= h) my = 0;
        end
    endtask

    task automatic set_scene(input int cx, cy, cz, sx, sy, sz, r);
        cam_x = cx; cam_y = cy; cam_z = cz; sph_x = sx; sph_y = sy; sph_z = sz; rad = r;
        camera_pos_x = 11'(cx); camera_pos_y = 11'(cy); camera_pos_z = 11'(cz);
        sphere_x = 11'(sx); sphere_y = 11'(sy); sphere_z = 11'(sz); sphere_r = 11'(r);
    endtask

    // Drive one ray, push its expectation, wait for the pixel and take it at once.
    // lat = index of the edge after which pix_valid is first seen (accept edge = 0).
    task automatic run_ray(input longint dx, dy, dz, output pix_t got, output int lat,
                           output logic fd, output logic rdy);
        int w;
        sb.push_back(model(dx, dy, dz));
        next_coord();
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        ray_dir_x = 32'(dx); ray_dir_y = 32'(dy); ray_dir_z = 32'(dz);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ray_dir_x = $urandom; ray_dir_y = $urandom; ray_dir_z = $urandom;
        sphere_r = 11'($urandom); camera_pos_z = 11'($urandom);
        lat = 0;
        while (pix_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        got = {pix_hit, pix_oor, pix_color, pix_x, pix_y};
        sphere_r = 11'(rad); camera_pos_z = 11'(cam_z);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        fd = frame_done;
        rdy = in_ready;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tests_run++;
        if ({pix_valid, pix_hit, pix_oor, frame_done, pix_color, pix_x, pix_y} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v%b h%b o%b fd%b c%h x%0d y%0d expected all 0",
                     pix_valid, pix_hit, pix_oor, frame_done, pix_color, pix_x, pix_y);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_hit();
        pix_t got, e; int lat; logic fd, rdy;
        set_scene(0, 0, 0, 0, 0, 100, 10);
        run_ray(0, 0, 100, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL hit_pixel: got %h expected %h", got, e); end
        tests_run++;
        if (got.hit !== 1'b1 || got.color !== 8'hFF || got.oor !== 1'b0) begin
            tests_failed++; $display("FAIL hit_shade: got hit %b color %h expected 1 ff", got.hit, got.color);
        end
        tests_run++;
        if (lat !== 12) begin tests_failed++; $display("FAIL hit_latency: got %0d expected 12", lat); end
    endtask

    task automatic test_miss();
        pix_t got, e; int lat; logic fd, rdy;
        run_ray(50, 0, 100, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e || got.hit !== 1'b0 || got.color !== 8'h20) begin
            tests_failed++; $display("FAIL miss_pixel: got %h expected %h", got, e);
        end
        run_ray(0, 0, -100, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e || got.hit !== 1'b0 || got.color !== 8'h20) begin
            tests_failed++; $display("FAIL behind_pixel: got %h expected %h", got, e);
        end
    endtask

    task automatic test_oor();
        pix_t got, e; int lat; logic fd, rdy;
        run_ray(40000, 0, 100, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e || got.oor !== 1'b1 || got.hit !== 1'b0 || got.color !== 8'h20) begin
            tests_failed++; $display("FAIL oor_pixel: got %h expected %h", got, e);
        end
        tests_run++;
        if (lat !== 0) begin tests_failed++; $display("FAIL oor_latency: got edge %0d expected 0", lat); end
        run_ray(-32769, 0, 100, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e || got.oor !== 1'b1) begin tests_failed++; $display("FAIL oor_low_edge: got %h expected %h", got, e); end
        run_ray(32767, -32768, 0, got, lat, fd, rdy);
        e = sb.pop_front();
        tests_run++;
        if (got !== e || got.oor !== 1'b0 || lat !== 12) begin
            tests_failed++; $display("FAIL in_range_edge: got %h lat %0d expected %h lat 12", got, lat, e);
        end
    endtask

    task automatic test_random();
        pix_t got, e; int lat; logic fd, rdy;
        for (int i = 0; i < 10; i++) begin
            longint dx, dy, dz;
            int k;
            set_scene($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                      $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                      $urandom_range(0, 2047));
            k = $urandom_range(1, 15);
            dx = longint'(sph_x - cam_x) * k + $urandom_range(0, 400) - 200;
            dy = longint'(sph_y - cam_y) * k + $urandom_range(0, 400) - 200;
            dz = longint'(sph_z - cam_z) * k + $urandom_range(0, 400) - 200;
            if (i % 4 == 3) dy = -dy;
            if (i == 7) dz = 70000;
            run_ray(dx, dy, dz, got, lat, fd, rdy);
            e = sb.pop_front();
            tests_run++;
            if (got !== e || lat !== (e.oor ? 0 : 12)) begin
                tests_failed++;
                $display("FAIL random_%0d: got %h lat %0d expected %h lat %0d", i, got, lat, e, e.oor ? 0 : 12);
            end
        end
    endtask

    task automatic test_stall_reset();
        pix_t got, e, now; int w, bad;
        set_scene(0, 0, 0, 0, 0, 100, 10);
        sb.push_back(model(0, 0, 100));
        next_coord();
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (pix_valid !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
        got = {pix_hit, pix_oor, pix_color, pix_x, pix_y};
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            now = {pix_hit, pix_oor, pix_color, pix_x, pix_y};
            if (now !== got || pix_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
        e = sb.pop_front();
        tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL stall_pixel: got %h expected %h", got, e); end
        pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        // Second ray is abandoned by reset part-way through its calculation.
        ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, pix_valid, pix_hit, pix_oor, frame_done, pix_color, pix_x, pix_y} !== 39'd0) begin
            tests_failed++;
            $display("FAIL midcalc_reset: got r%b v%b h%b o%b fd%b c%h x%0d y%0d expected all 0",
                     in_ready, pix_valid, pix_hit, pix_oor, frame_done, pix_color, pix_x, pix_y);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        mx = 0; my = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (pix_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL post_reset_idle: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_frame();
        pix_t got, e; int lat; logic fd, rdy;
        image_width = 13'd2; image_height = 13'd2;
        set_scene(0, 0, 0, 0, 0, 100, 10);
        for (int i = 0; i < 4; i++) begin
            run_ray(0, 0, 100, got, lat, fd, rdy);
            e = sb.pop_front();
            tests_run++;
            if (got !== e || got.x !== 13'(i % 2) || got.y !== 13'(i / 2)) begin
                tests_failed++;
                $display("FAIL frame_coord_%0d: got (%0d,%0d) %h expected (%0d,%0d) %h", i, got.x, got.y, got, i % 2, i / 2, e);
            end
            tests_run++;
            if (fd !== (i == 3) || rdy !== 1'b1 || pix_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL frame_done_%0d: got fd %b rdy %b vld %b expected fd %b rdy 1 vld 0", i, fd, rdy, pix_valid, i == 3);
            end
        end
        tests_run++;
        if (pix_x !== 13'd0 || pix_y !== 13'd0) begin
            tests_failed++; $display("FAIL frame_wrap: got (%0d,%0d) expected (0,0)", pix_x, pix_y);
        end
        @(posedge clk); #1;
        tests_run++;
        if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL frame_pulse: got %b expected 0", frame_done); end
    endtask

    initial begin
        in_valid = 1'b0; pix_ready = 1'b0;
        ray_dir_x = '0; ray_dir_y = '0; ray_dir_z = '0;
        image_width = 13'd640; image_height = 13'd480;
        set_scene(0, 0, 0, 0, 0, 100, 10);
        test_reset();
        test_hit();
        test_miss();
        test_oor();
        test_random();
        test_stall_reset();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
